// File: rtl/action_pkg.sv
// -----------------------------------------------------------------------------
// action_pkg
// Shared definitions for the action dispatch slice: action code values, the
// action code width and the dispatcher FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package action_pkg;

    localparam int NUM_ACTIONS = 5;
    localparam int ACT_W       = 3;

    localparam logic [ACT_W-1:0] ACT_KICK  = 3'd0;
    localparam logic [ACT_W-1:0] ACT_PUNCH = 3'd1;
    localparam logic [ACT_W-1:0] ACT_LEFT  = 3'd2;
    localparam logic [ACT_W-1:0] ACT_RIGHT = 3'd3;
    localparam logic [ACT_W-1:0] ACT_WAIT  = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        COOLDOWN
    } state_e;

endpackage

// File: rtl/action_fifo.sv
// -----------------------------------------------------------------------------
// action_fifo
// Synchronous FIFO holding queued action codes. A push while full is still
// accepted when a pop happens on the same edge (the freed slot is reused).
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   push, push_data  write request and data
//   pop            read request (ignored when empty)
//   head           entry at the read pointer
//   head_next      entry one past the read pointer (head after a pop)
//   count          entries held
//   full, empty    status from the registered count
//   push_ok        push request accepted this edge
// -----------------------------------------------------------------------------
module action_fifo
    import action_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ACT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [WIDTH-1:0]       head_next,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   push_ok
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_ok;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign pop_ok    = pop && !empty;
    assign push_ok   = push && (!full || pop_ok);
    assign head      = mem[rd_ptr];
    assign head_next = mem[rd_ptr + PTR_W'(1)];

    // Storage needs no reset; stale entries are never presented because
    // the count gates everything downstream.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/action_dispatch.sv
// -----------------------------------------------------------------------------
// action_dispatch
// Turns one-hot purchase grant pulses into queued action codes and hands them
// to the game engine over a valid/ready handshake, with a programmable idle
// gap (COOLDOWN cycles) after each dispatch.
// Optional feature macro: ACTION_DISPATCH_STATS_EN adds saturating
// stat_dispatched / stat_dropped counters.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   grant_onehot      purchase pulse, bit i = action code i
//   act_valid/act_code/act_ready  engine handshake (registered outputs)
//   fifo_count, full, empty       queue status
//   err_overflow      pulse: valid grant dropped because queue full
//   err_multihot      pulse: grant had more than one bit set
//   stat_dispatched, stat_dropped (only with ACTION_DISPATCH_STATS_EN)
// -----------------------------------------------------------------------------
module action_dispatch #(
    parameter int DEPTH    = 4,
    parameter int COOLDOWN = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [4:0]                   grant_onehot,
    output logic                         act_valid,
    output logic [action_pkg::ACT_W-1:0] act_code,
    input  logic                         act_ready,
    output logic [$clog2(DEPTH):0]       fifo_count,
    output logic                         full,
    output logic                         empty,
    output logic                         err_overflow,
    output logic                         err_multihot
`ifdef ACTION_DISPATCH_STATS_EN
    ,
    output logic [15:0]                  stat_dispatched,
    output logic [7:0]                   stat_dropped
`endif
);

    import action_pkg::*;

    localparam int         CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [7:0] CD_LOAD = (COOLDOWN > 0) ? 8'(COOLDOWN - 1) : 8'd0;

    action_pkg::state_e state, state_n;

    logic             multihot;
    logic             single;
    logic [ACT_W-1:0] push_code;
    logic             push_ok;
    logic             pop;
    logic [ACT_W-1:0] head;
    logic [ACT_W-1:0] head_next;
    logic             post_pop_nonempty;
    logic             act_valid_n;
    logic [ACT_W-1:0] act_code_n;
    logic [7:0]       cd_cnt, cd_cnt_n;

    // A grant is one-hot exactly when clearing its lowest set bit leaves zero.
    assign multihot = ((grant_onehot & (grant_onehot - 5'd1)) != 5'd0);
    assign single   = (grant_onehot != 5'd0) && !multihot;
    assign pop      = act_valid && act_ready;

    always_comb begin
        push_code = '0;
        for (int i = 0; i < NUM_ACTIONS; i++) begin
            if (grant_onehot[i]) begin
                push_code = ACT_W'(i);
            end
        end
    end

    action_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ACT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (single),
        .push_data (push_code),
        .pop       (pop),
        .head      (head),
        .head_next (head_next),
        .count     (fifo_count),
        .full      (full),
        .empty     (empty),
        .push_ok   (push_ok)
    );

    assign post_pop_nonempty = (fifo_count > CNT_W'(1)) || push_ok;

    // State register; act_valid/act_code/cd_cnt are registered alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= action_pkg::IDLE;
            act_valid <= 1'b0;
            act_code  <= '0;
            cd_cnt    <= 8'd0;
        end else begin
            state     <= state_n;
            act_valid <= act_valid_n;
            act_code  <= act_code_n;
            cd_cnt    <= cd_cnt_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            action_pkg::IDLE: begin
                if (!empty) begin
                    state_n = action_pkg::PRESENT;
                end
            end
            action_pkg::PRESENT: begin
                if (pop) begin
                    if (COOLDOWN > 0) begin
                        state_n = action_pkg::COOLDOWN;
                    end else if (post_pop_nonempty) begin
                        state_n = action_pkg::PRESENT;
                    end else begin
                        state_n = action_pkg::IDLE;
                    end
                end
            end
            action_pkg::COOLDOWN: begin
                if (cd_cnt == 8'd0) begin
                    state_n = empty ? action_pkg::IDLE : action_pkg::PRESENT;
                end
            end
            default: state_n = action_pkg::IDLE;
        endcase
    end

    // Next values of the registered outputs. On a back-to-back pop the new
    // head is the second FIFO entry, or the word being pushed on this same
    // edge when the FIFO held only the popped entry.
    always_comb begin
        act_valid_n = (state_n == action_pkg::PRESENT);
        act_code_n  = '0;
        cd_cnt_n    = cd_cnt;
        if (state_n == action_pkg::PRESENT) begin
            if (pop) begin
                act_code_n = (fifo_count > CNT_W'(1)) ? head_next : push_code;
            end else begin
                act_code_n = head;
            end
        end
        if (state == action_pkg::PRESENT && pop && COOLDOWN > 0) begin
            cd_cnt_n = CD_LOAD;
        end else if (state == action_pkg::COOLDOWN && cd_cnt != 8'd0) begin
            cd_cnt_n = cd_cnt - 8'd1;
        end
    end

    // Error pulses appear in the cycle after the offending edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_overflow <= 1'b0;
            err_multihot <= 1'b0;
        end else begin
            err_overflow <= single && !push_ok;
            err_multihot <= multihot;
        end
    end

`ifdef ACTION_DISPATCH_STATS_EN
    logic [1:0] drop_inc;
    logic [8:0] drop_sum;

    assign drop_inc = {1'b0, single && !push_ok} + {1'b0, multihot};
    assign drop_sum = {1'b0, stat_dropped} + 9'(drop_inc);

    // Both counters saturate instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_dispatched <= 16'd0;
            stat_dropped    <= 8'd0;
        end else begin
            if (pop && stat_dispatched != 16'hFFFF) begin
                stat_dispatched <= stat_dispatched + 16'd1;
            end
            stat_dropped <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end
`endif

endmodule

// File: tb/tb_action_dispatch.sv
// -----------------------------------------------------------------------------
// tb_action_dispatch
// Directed bench for action_dispatch. Two instances share clock and reset:
// dut (COOLDOWN=3) and dut0 (COOLDOWN=0). Expected action codes are queued
// when a grant is driven and compared when a handshake is seen.
// -----------------------------------------------------------------------------
module tb_action_dispatch;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    grant = '0;
    logic [4:0]    grant0 = '0;
    logic          ready  = 1'b0;
    logic          ready0 = 1'b0;

    logic          act_valid, act_valid0;
    logic [2:0]    act_code, act_code0;
    logic [CW-1:0] fifo_count, fifo_count0;
    logic          full, full0, empty, empty0;
    logic          err_ov, err_ov0, err_mh, err_mh0;
`ifdef ACTION_DISPATCH_STATS_EN
    logic [15:0]   stat_disp, stat_disp0;
    logic [7:0]    stat_drop, stat_drop0;
`endif

    int total = 0;
    int bad   = 0;
    logic [2:0] exp_q[$];
    logic [2:0] exp_q0[$];

    always #5 clk = ~clk;

    action_dispatch #(.DEPTH(DEPTH), .COOLDOWN(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .grant_onehot (grant),
        .act_valid    (act_valid),
        .act_code     (act_code),
        .act_ready    (ready),
        .fifo_count   (fifo_count),
        .full         (full),
        .empty        (empty),
        .err_overflow (err_ov),
        .err_multihot (err_mh)
`ifdef ACTION_DISPATCH_STATS_EN
        ,
        .stat_dispatched (stat_disp),
        .stat_dropped    (stat_drop)
`endif
    );

    action_dispatch #(.DEPTH(DEPTH), .COOLDOWN(0)) dut0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .grant_onehot (grant0),
        .act_valid    (act_valid0),
        .act_code     (act_code0),
        .act_ready    (ready0),
        .fifo_count   (fifo_count0),
        .full         (full0),
        .empty        (empty0),
        .err_overflow (err_ov0),
        .err_multihot (err_mh0)
`ifdef ACTION_DISPATCH_STATS_EN
        ,
        .stat_dispatched (stat_disp0),
        .stat_dropped    (stat_drop0)
`endif
    );

    // One comparison: counted, and reported with tag/observed/expected on failure.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of stimulus on instance sel (0: dut, 1: dut0), clock it,
    // then check error pulses and occupancy against the bench's own model.
    task automatic applyStimulus(input bit sel, input logic [4:0] g,
                                 input logic rdy, input bit push_exp);
        bit         multi;
        bit         single;
        logic [2:0] code;
        multi  = ((g & (g - 5'd1)) != 5'd0);
        single = (g != 5'd0) && !multi;
        code   = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (g[i]) code = 3'(i);
        end
        if (sel == 1'b0) begin
            grant = g;
            ready = rdy;
            if (push_exp) exp_q.push_back(code);
        end else begin
            grant0 = g;
            ready0 = rdy;
            if (push_exp) exp_q0.push_back(code);
        end
        @(posedge clk);
        #1;
        if (sel == 1'b0) begin
            grant = '0;
            checkOutput("err_overflow", 32'(err_ov), 32'(single && !push_exp));
            checkOutput("err_multihot", 32'(err_mh), 32'(multi));
            checkOutput("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
        end else begin
            grant0 = '0;
            checkOutput("err_overflow0", 32'(err_ov0), 32'(single && !push_exp));
            checkOutput("err_multihot0", 32'(err_mh0), 32'(multi));
            checkOutput("fifo_count0", 32'(fifo_count0), 32'(exp_q0.size()));
        end
    endtask

    // Scoreboards: a handshake visible before the edge must carry the oldest
    // queued code.
    always @(negedge clk) begin
        if (rst_n && act_valid && ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_dispatch", 32'(act_code), 32'hFFFF_FFFF);
            end else begin
                checkOutput("dispatch_code", 32'(act_code), 32'(exp_q.pop_front()));
            end
        end
        if (rst_n && act_valid0 && ready0) begin
            if (exp_q0.size() == 0) begin
                checkOutput("unexpected_dispatch0", 32'(act_code0), 32'hFFFF_FFFF);
            end else begin
                checkOutput("dispatch_code0", 32'(act_code0), 32'(exp_q0.pop_front()));
            end
        end
    end

    initial begin
        // Reset values.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_act_valid", 32'(act_valid), 32'd0);
        checkOutput("rst_act_code", 32'(act_code), 32'd0);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_fifo_count", 32'(fifo_count), 32'd0);
        checkOutput("rst_err_ov", 32'(err_ov), 32'd0);
        checkOutput("rst_err_mh", 32'(err_mh), 32'd0);
        rst_n = 1'b1;

        // Single grant: valid two edges after the grant, then 3 idle cycles.
        applyStimulus(0, 5'b00100, 1'b1, 1'b1);
        checkOutput("lat_valid_e0", 32'(act_valid), 32'd0);
        applyStimulus(0, 5'b00000, 1'b1, 1'b0);
        checkOutput("lat_valid_e1", 32'(act_valid), 32'd1);
        checkOutput("lat_code_e1", 32'(act_code), 32'd2);
        applyStimulus(0, 5'b00000, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("cd1_valid_low", 32'(act_valid), 32'd0);
            checkOutput("cd1_empty", 32'(empty), 32'd1);
            applyStimulus(0, 5'b00000, 1'b1, 1'b0);
        end
        applyStimulus(0, 5'b00000, 1'b0, 1'b0);

        // Three queued grants held by ready=0, then released in order.
        applyStimulus(0, 5'b00001, 1'b0, 1'b1);
        applyStimulus(0, 5'b00010, 1'b0, 1'b1);
        applyStimulus(0, 5'b10000, 1'b0, 1'b1);
        checkOutput("q3_count", 32'(fifo_count), 32'd3);
        checkOutput("q3_valid", 32'(act_valid), 32'd1);
        checkOutput("q3_code", 32'(act_code), 32'd0);
        applyStimulus(0, 5'b00000, 1'b0, 1'b0);
        checkOutput("q3_code_stable", 32'(act_code), 32'd0);
        applyStimulus(0, 5'b00000, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) begin
                checkOutput("q3_gap_low", 32'(act_valid), 32'd0);
                applyStimulus(0, 5'b00000, 1'b1, 1'b0);
            end
            checkOutput("q3_gap_reassert", 32'(act_valid), 32'd1);
            checkOutput("q3_next_code", 32'(act_code), (k == 0) ? 32'd1 : 32'd4);
            applyStimulus(0, 5'b00000, 1'b1, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            checkOutput("q3_tail_low", 32'(act_valid), 32'd0);
            applyStimulus(0, 5'b00000, 1'b0, 1'b0);
        end
        checkOutput("q3_empty", 32'(empty), 32'd1);

        // Fill to DEPTH, two consecutive overflow pulses, then full+pop+push.
        applyStimulus(0, 5'b00001, 1'b0, 1'b1);
        applyStimulus(0, 5'b00010, 1'b0, 1'b1);
        applyStimulus(0, 5'b00100, 1'b0, 1'b1);
        applyStimulus(0, 5'b01000, 1'b0, 1'b1);
        checkOutput("fill_full", 32'(full), 32'd1);
        applyStimulus(0, 5'b10000, 1'b0, 1'b0);
        applyStimulus(0, 5'b00001, 1'b0, 1'b0);
        checkOutput("ovf_count", 32'(fifo_count), 32'd4);
        applyStimulus(0, 5'b00000, 1'b0, 1'b0);
        checkOutput("ovf_full_valid", 32'(act_valid), 32'd1);
        applyStimulus(0, 5'b00100, 1'b1, 1'b1);
        checkOutput("fullpop_full", 32'(full), 32'd1);
        for (int i = 0; i < 20; i++) applyStimulus(0, 5'b00000, 1'b1, 1'b0);
        checkOutput("drain_q_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("drain_empty", 32'(empty), 32'd1);

        // Malformed grants and an all-zero grant.
        applyStimulus(0, 5'b00011, 1'b0, 1'b0);
        applyStimulus(0, 5'b11000, 1'b0, 1'b0);
        applyStimulus(0, 5'b00000, 1'b0, 1'b0);
        checkOutput("mh_valid", 32'(act_valid), 32'd0);

        // COOLDOWN=0 instance: back-to-back dispatch with a push during a pop.
        applyStimulus(1, 5'b01000, 1'b0, 1'b1);
        applyStimulus(1, 5'b00010, 1'b0, 1'b1);
        applyStimulus(1, 5'b10000, 1'b0, 1'b1);
        checkOutput("b2b_valid_0", 32'(act_valid0), 32'd1);
        checkOutput("b2b_code_0", 32'(act_code0), 32'd3);
        applyStimulus(1, 5'b00100, 1'b1, 1'b1);
        checkOutput("b2b_valid_1", 32'(act_valid0), 32'd1);
        checkOutput("b2b_code_1", 32'(act_code0), 32'd1);
        applyStimulus(1, 5'b00000, 1'b1, 1'b0);
        checkOutput("b2b_valid_2", 32'(act_valid0), 32'd1);
        checkOutput("b2b_code_2", 32'(act_code0), 32'd4);
        applyStimulus(1, 5'b00000, 1'b1, 1'b0);
        checkOutput("b2b_valid_3", 32'(act_valid0), 32'd1);
        checkOutput("b2b_code_3", 32'(act_code0), 32'd2);
        applyStimulus(1, 5'b00000, 1'b1, 1'b0);
        checkOutput("b2b_valid_end", 32'(act_valid0), 32'd0);
        checkOutput("b2b_empty", 32'(empty0), 32'd1);

        // Reset asserted while presenting with two entries queued.
        applyStimulus(0, 5'b00100, 1'b0, 1'b1);
        applyStimulus(0, 5'b01000, 1'b0, 1'b1);
        applyStimulus(0, 5'b00000, 1'b0, 1'b0);
        checkOutput("pre_rst_valid", 32'(act_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", 32'(act_valid), 32'd0);
        checkOutput("midrst_count", 32'(fifo_count), 32'd0);
        checkOutput("midrst_empty", 32'(empty), 32'd1);
        exp_q.delete();
        exp_q0.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

`ifdef ACTION_DISPATCH_STATS_EN
        // Statistics: one overflow drop, then three dispatches.
        checkOutput("stat_disp_rst", 32'(stat_disp), 32'd0);
        checkOutput("stat_drop_rst", 32'(stat_drop), 32'd0);
        applyStimulus(0, 5'b00001, 1'b0, 1'b1);
        applyStimulus(0, 5'b00010, 1'b0, 1'b1);
        applyStimulus(0, 5'b00100, 1'b0, 1'b1);
        applyStimulus(0, 5'b01000, 1'b0, 1'b1);
        applyStimulus(0, 5'b10000, 1'b0, 1'b0);
        checkOutput("stat_drop_1", 32'(stat_drop), 32'd1);
        for (int i = 0; i < 40 && exp_q.size() > 1; i++) begin
            applyStimulus(0, 5'b00000, 1'b1, 1'b0);
        end
        checkOutput("stat_disp_3", 32'(stat_disp), 32'd3);
        checkOutput("stat_drop_still_1", 32'(stat_drop), 32'd1);
        for (int i = 0; i < 12; i++) applyStimulus(0, 5'b00000, 1'b1, 1'b0);
`endif

        applyStimulus(0, 5'b00000, 1'b0, 1'b0);
        checkOutput("final_q_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("final_q0_empty", 32'(exp_q0.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
